// File: rtl/cc_cond_unit.sv
// Execute-stage ALU, condition-code register and condition evaluation.
// Also carries the registered M-stage condition and a saturating taken-condition counter.
module cc_cond_unit #(
    parameter int unsigned WIDTH    = 64,
    parameter bit          EXT_COND = 1'b0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [1:0]       alufun_i,
    input  logic [WIDTH-1:0] aluA_i,
    input  logic [WIDTH-1:0] aluB_i,
    input  logic             set_cc_i,
    input  logic [3:0]       E_ifun_i,
    input  logic             eval_i,
    input  logic             m_exc_i,
    input  logic             W_exc_i,
    input  logic             stall_i,
    input  logic             bubble_i,
    input  logic             clr_cnt_i,
    output logic [WIDTH-1:0] e_valE_o,
    output logic             e_Cnd_o,
    output logic             M_Cnd_o,
    output logic [3:0]       cc_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    typedef enum logic [1:0] {AluAdd, AluSub, AluAnd, AluXor} alu_op_e;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             a_msb, b_msb;
    logic             zf_n, sf_n, of_n, cf_n;
    logic             cc_write;
    logic             zf, sf, of, cf;
    logic             cnd;

    logic [3:0]       cc_d, cc_q;
    logic             m_cnd_d, m_cnd_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign a_msb = aluA_i[WIDTH-1];
    assign b_msb = aluB_i[WIDTH-1];

    always_comb begin
        sum  = {1'b0, aluB_i} + {1'b0, aluA_i};
        // Top bit of the widened difference is the unsigned borrow (B < A).
        diff = {1'b0, aluB_i} - {1'b0, aluA_i};
        res  = '0;
        of_n = 1'b0;
        cf_n = 1'b0;
        unique case (alu_op_e'(alufun_i))
            AluAdd: begin
                res  = sum[WIDTH-1:0];
                of_n = (a_msb == b_msb) && (res[WIDTH-1] != a_msb);
                cf_n = sum[WIDTH];
            end
            AluSub: begin
                res  = diff[WIDTH-1:0];
                of_n = (a_msb != b_msb) && (res[WIDTH-1] != b_msb);
                cf_n = diff[WIDTH];
            end
            AluAnd: res = aluA_i & aluB_i;
            AluXor: res = aluA_i ^ aluB_i;
        endcase
        if (!EXT_COND) cf_n = 1'b0;
        zf_n = (res == '0);
        sf_n = res[WIDTH-1];
    end

    assign e_valE_o = res;

    // Conditions look only at the stored flags, never at this cycle's result.
    assign cf = cc_q[3];
    assign of = cc_q[2];
    assign sf = cc_q[1];
    assign zf = cc_q[0];

    always_comb begin
        cnd = 1'b0;
        case (E_ifun_i)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = (sf ^ of) | zf;
            4'd2:    cnd = sf ^ of;
            4'd3:    cnd = zf;
            4'd4:    cnd = ~zf;
            4'd5:    cnd = ~(sf ^ of);
            4'd6:    cnd = ~(sf ^ of) & ~zf;
            4'd7:    cnd = EXT_COND & cf;
            4'd8:    cnd = EXT_COND & ~cf;
            4'd9:    cnd = EXT_COND & ~cf & ~zf;
            4'd10:   cnd = EXT_COND & (cf | zf);
            default: cnd = 1'b0;
        endcase
    end

    assign e_Cnd_o = cnd;

    always_comb begin
        cc_write = set_cc_i & ~stall_i & ~m_exc_i & ~W_exc_i;
        cc_d     = cc_write ? {cf_n, of_n, sf_n, zf_n} : cc_q;

        if (stall_i) begin
            m_cnd_d = m_cnd_q;
        end else if (bubble_i) begin
            m_cnd_d = 1'b0;
        end else begin
            m_cnd_d = cnd;
        end

        cnt_d = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (eval_i && cnd && !stall_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cc_q    <= 4'b0001;
            m_cnd_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cc_q    <= cc_d;
            m_cnd_q <= m_cnd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cc_o        = cc_q;
    assign M_Cnd_o     = m_cnd_q;
    assign taken_cnt_o = cnt_q;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Bench for cc_cond_unit: directed scenarios plus randomized traffic against a flag/condition model.
// Two instances share stimulus: one with extended conditions, one without.
module tb_cc_cond_unit;

    localparam int W    = 64;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    alufun;
    logic [W-1:0]  a, b;
    logic          set_cc, eval, m_exc, w_exc, stall, bubble, clr;
    logic [3:0]    ifun;

    logic [W-1:0]  val1, val0;
    logic          cnd1, cnd0, mc1, mc0;
    logic [3:0]    cc1, cc0;
    logic [CW-1:0] cnt1, cnt0;

    int total = 0;
    int bad   = 0;

    bit [3:0] m_cc[2];
    bit       m_mc[2];
    int       m_cnt[2];

    always #5 clk = ~clk;

    cc_cond_unit #(.WIDTH(W), .EXT_COND(1'b1), .CNT_W(CW)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .alufun_i(alufun), .aluA_i(a), .aluB_i(b),
        .set_cc_i(set_cc), .E_ifun_i(ifun), .eval_i(eval), .m_exc_i(m_exc), .W_exc_i(w_exc),
        .stall_i(stall), .bubble_i(bubble), .clr_cnt_i(clr),
        .e_valE_o(val1), .e_Cnd_o(cnd1), .M_Cnd_o(mc1), .cc_o(cc1), .taken_cnt_o(cnt1)
    );

    cc_cond_unit #(.WIDTH(W), .EXT_COND(1'b0), .CNT_W(CW)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .alufun_i(alufun), .aluA_i(a), .aluB_i(b),
        .set_cc_i(set_cc), .E_ifun_i(ifun), .eval_i(eval), .m_exc_i(m_exc), .W_exc_i(w_exc),
        .stall_i(stall), .bubble_i(bubble), .clr_cnt_i(clr),
        .e_valE_o(val0), .e_Cnd_o(cnd0), .M_Cnd_o(mc0), .cc_o(cc0), .taken_cnt_o(cnt0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_cond(input logic [3:0] code, input bit [3:0] cc, input bit ext);
        bit zf, sf, of, cf, lt;
        zf = cc[0]; sf = cc[1]; of = cc[2]; cf = cc[3];
        lt = sf != of;
        case (code)
            0:  return 1'b1;
            1:  return lt || zf;
            2:  return lt;
            3:  return zf;
            4:  return !zf;
            5:  return !lt;
            6:  return !lt && !zf;
            7:  return ext && cf;
            8:  return ext && !cf;
            9:  return ext && !cf && !zf;
            10: return ext && (cf || zf);
            default: return 1'b0;
        endcase
    endfunction

    // Flags from exact arithmetic: overflow when the true signed result does not fit in W bits.
    task automatic ref_flags(input logic [1:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input bit ext, output logic [W-1:0] res, output bit [3:0] fl);
        logic signed [W+1:0] sa, sb, st;
        bit of, cf;
        sa = {{2{ia[W-1]}}, ia};
        sb = {{2{ib[W-1]}}, ib};
        of = 1'b0;
        cf = 1'b0;
        case (op)
            2'd0: begin
                res = ib + ia;
                st  = sb + sa;
                of  = st != {{2{res[W-1]}}, res};
                cf  = ia > ~ib;
            end
            2'd1: begin
                res = ib - ia;
                st  = sb - sa;
                of  = st != {{2{res[W-1]}}, res};
                cf  = ib < ia;
            end
            2'd2: res = ia & ib;
            default: res = ia ^ ib;
        endcase
        if (!ext) cf = 1'b0;
        fl = {cf, of, res[W-1], res == '0};
    endtask

    task automatic model_reset();
        for (int e = 0; e < 2; e++) begin
            m_cc[e]  = 4'b0001;
            m_mc[e]  = 1'b0;
            m_cnt[e] = 0;
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_cc1"}, cc1, m_cc[1]);
        check({tag, "_cc0"}, cc0, m_cc[0]);
        check({tag, "_mc1"}, mc1, m_mc[1]);
        check({tag, "_mc0"}, mc0, m_mc[0]);
        check({tag, "_cnt1"}, cnt1, m_cnt[1]);
        check({tag, "_cnt0"}, cnt0, m_cnt[0]);
    endtask

    // Called between a rising edge and the next one, with inputs already driven.
    task automatic cycle();
        logic [W-1:0] res;
        bit [3:0]     fl[2];
        bit           c[2];
        #1;
        for (int e = 0; e < 2; e++) begin
            ref_flags(alufun, a, b, e[0], res, fl[e]);
            c[e] = ref_cond(ifun, m_cc[e], e[0]);
        end
        check("valE", val1, res);
        check("valE_base", val0, res);
        check("cnd1", cnd1, c[1]);
        check("cnd0", cnd0, c[0]);
        @(posedge clk);
        for (int e = 0; e < 2; e++) begin
            if (set_cc && !stall && !m_exc && !w_exc) m_cc[e] = fl[e];
            if (!stall) m_mc[e] = bubble ? 1'b0 : c[e];
            if (clr) m_cnt[e] = 0;
            else if (eval && c[e] && !stall && m_cnt[e] < CMAX) m_cnt[e]++;
        end
        #1;
        check_regs("clk");
    endtask

    task automatic idle_inputs();
        alufun = 2'd0; a = '0; b = '0; set_cc = 1'b0; ifun = 4'd0; eval = 1'b0;
        m_exc = 1'b0; w_exc = 1'b0; stall = 1'b0; bubble = 1'b0; clr = 1'b0;
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners[6];
        corners[0] = '0;
        corners[1] = '1;
        corners[2] = {1'b0, {(W-1){1'b1}}};
        corners[3] = {1'b1, {(W-1){1'b0}}};
        corners[4] = 64'd1;
        corners[5] = 64'd5;
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
        return {$urandom, $urandom};
    endfunction

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("reset");

        ifun = 4'd3;
        #1 check("rst_e", cnd1, 1'b1);
        ifun = 4'd4;
        #1 check("rst_ne", cnd1, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        // SUB 3-5: negative, borrow, no overflow.
        alufun = 2'd1; a = 64'd5; b = 64'd3; set_cc = 1'b1; ifun = 4'd0;
        #1 check("sub_val", val1, 64'hFFFF_FFFF_FFFF_FFFE);
        cycle();
        check("sub_cc", cc1, 4'b1010);
        set_cc = 1'b0;
        ifun = 4'd2; #1 check("sub_l", cnd1, 1'b1);
        ifun = 4'd6; #1 check("sub_g", cnd1, 1'b0);
        ifun = 4'd7; #1 check("sub_b", cnd1, 1'b1);
        ifun = 4'd9; #1 check("sub_a", cnd1, 1'b0);

        // ADD of two max positives: signed overflow, no carry.
        alufun = 2'd0; a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'h7FFF_FFFF_FFFF_FFFF; set_cc = 1'b1;
        #1 check("add_val", val1, 64'hFFFF_FFFF_FFFF_FFFE);
        cycle();
        check("add_cc", cc1, 4'b0110);
        check("add_cc_base", cc0, 4'b0110);
        set_cc = 1'b0;
        ifun = 4'd2; #1 check("add_l", cnd1, 1'b0);
        ifun = 4'd5; #1 check("add_ge", cnd1, 1'b1);
        ifun = 4'd7; #1 check("add_b_base", cnd0, 1'b0);

        // Blocked CC writes.
        alufun = 2'd1; a = 64'd5; b = 64'd3; set_cc = 1'b1;
        m_exc = 1'b1; cycle(); check("mexc_hold", cc1, 4'b0110); m_exc = 1'b0;
        w_exc = 1'b1; cycle(); check("wexc_hold", cc1, 4'b0110); w_exc = 1'b0;
        stall = 1'b1; cycle(); check("stall_hold", cc1, 4'b0110); stall = 1'b0;
        set_cc = 1'b0;

        // M_Cnd stall beats bubble.
        ifun = 4'd0;
        cycle(); check("mc_load", mc1, 1'b1);
        stall = 1'b1; bubble = 1'b1;
        cycle(); check("mc_stall", mc1, 1'b1);
        stall = 1'b0;
        cycle(); check("mc_bubble", mc1, 1'b0);
        bubble = 1'b0;

        // Counter saturation and clear.
        clr = 1'b1; cycle(); clr = 1'b0;
        eval = 1'b1; ifun = 4'd0;
        for (int i = 0; i < 16; i++) cycle();
        check("cnt_sat", cnt1, 4'd15);
        clr = 1'b1;
        cycle();
        check("cnt_clr", cnt1, 4'd0);
        idle_inputs();

        // Reset mid set_cc discards the write.
        alufun = 2'd1; a = 64'd5; b = 64'd3; set_cc = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async_cc", cc1, 4'b0001);
        @(posedge clk);
        #1 check("rst_drop_cc", cc1, 4'b0001);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("post_rst_cc", cc1, 4'b1010);

        for (int n = 0; n < 400; n++) begin
            alufun = 2'($urandom_range(0, 3));
            a      = pick_operand();
            b      = pick_operand();
            set_cc = $urandom_range(0, 1) == 1;
            ifun   = 4'($urandom_range(0, 15));
            eval   = $urandom_range(0, 3) != 0;
            m_exc  = $urandom_range(0, 7) == 0;
            w_exc  = $urandom_range(0, 7) == 0;
            stall  = $urandom_range(0, 3) == 0;
            bubble = $urandom_range(0, 3) == 0;
            clr    = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 63) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_regs("rnd_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
